// File: rtl/fsm_write_data.sv
// Write-side sequencer for the shared game-state BRAM: snapshots game-logic outputs
// on request and writes changed fields to port A, one slot per cycle, fixed 8-cycle pass.
module fsm_write_data #(
  parameter logic [15:0] game_state_address     = 16'h800F,
  parameter logic [15:0] ball_x_address         = 16'h8008,
  parameter logic [15:0] ball_y_address         = 16'h8009,
  parameter logic [15:0] paddle1_y_address      = 16'h8002,
  parameter logic [15:0] paddle2_y_address      = 16'h8004,
  parameter logic [15:0] player_1_score_address = 16'h800D,
  parameter logic [15:0] player_2_score_address = 16'h800E,
  parameter bit          FORCE_ALL              = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        update_req,
  input  logic [1:0]  game_state,
  input  logic [9:0]  ball_x,
  input  logic [9:0]  ball_y,
  input  logic [9:0]  paddle1_y,
  input  logic [9:0]  paddle2_y,
  input  logic [6:0]  player_1_score,
  input  logic [6:0]  player_2_score,
  output logic [15:0] addr_a,
  output logic [15:0] data_a,
  output logic        wren_a,
  output logic        busy,
  output logic        done,
  output logic        req_dropped
);

  localparam int NSLOT = 7;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx, idx_nxt;
  logic [15:0] snap   [NSLOT];
  logic [15:0] shadow [NSLOT];
  logic        first_pass;
  logic        accept;
  logic        last;
  logic        dirty;
  logic [15:0] slot_data;
  logic [15:0] slot_shadow;

  function automatic logic [15:0] slot_address(input logic [2:0] i);
    logic [15:0] a;
    case (i)
      3'd0:    a = game_state_address;
      3'd1:    a = ball_x_address;
      3'd2:    a = ball_y_address;
      3'd3:    a = paddle1_y_address;
      3'd4:    a = paddle2_y_address;
      3'd5:    a = player_1_score_address;
      3'd6:    a = player_2_score_address;
      default: a = 16'h0000;
    endcase
    return a;
  endfunction

  assign accept = (state == IDLE) && update_req;

  // idx 7 is the closing cycle of a pass: nothing written, done pulsed
  always_comb begin
    slot_data   = '0;
    slot_shadow = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (idx == 3'(i)) begin
        slot_data   = snap[i];
        slot_shadow = shadow[i];
      end
    end
    last  = (idx == 3'd7);
    dirty = (slot_data != slot_shadow) || first_pass || FORCE_ALL;
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (update_req) begin
          state_nxt = WRITE;
          idx_nxt   = 3'd0;
        end
      end
      WRITE: begin
        if (last) begin
          state_nxt = IDLE;
          idx_nxt   = 3'd0;
        end else begin
          idx_nxt = idx + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Snapshot is pure data: only meaningful after an accept, so no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      snap[0] <= 16'(game_state);
      snap[1] <= 16'(ball_x);
      snap[2] <= 16'(ball_y);
      snap[3] <= 16'(paddle1_y);
      snap[4] <= 16'(paddle2_y);
      snap[5] <= 16'(player_1_score);
      snap[6] <= 16'(player_2_score);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSLOT; i++) shadow[i] <= '0;
    end else if ((state == WRITE) && !last && dirty) begin
      for (int i = 0; i < NSLOT; i++) begin
        if (idx == 3'(i)) shadow[i] <= slot_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_a      <= '0;
      data_a      <= '0;
      wren_a      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      req_dropped <= 1'b0;
      first_pass  <= 1'b1;
    end else begin
      addr_a <= '0;
      data_a <= '0;
      wren_a <= 1'b0;
      done   <= 1'b0;
      if (accept) busy <= 1'b1;
      if (state == WRITE) begin
        if (last) begin
          busy       <= 1'b0;
          done       <= 1'b1;
          first_pass <= 1'b0;
        end else begin
          // clean slots still present address/data so the bus stays traceable
          addr_a <= slot_address(idx);
          data_a <= slot_data;
          wren_a <= dirty;
        end
      end
      if ((state != IDLE) && update_req) req_dropped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fsm_write_data.sv
// Scoreboard bench for fsm_write_data: a pass-level reference model predicts writes,
// done pulses, busy and req_dropped for a change-only DUT and a FORCE_ALL DUT.
module tb_fsm_write_data;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       update_req = 1'b0;
  logic [1:0] game_state = '0;
  logic [9:0] ball_x = '0, ball_y = '0, paddle1_y = '0, paddle2_y = '0;
  logic [6:0] player_1_score = '0, player_2_score = '0;

  logic [15:0] addr_m [2];
  logic [15:0] data_m [2];
  logic        wren_m [2];
  logic        busy_m [2];
  logic        done_m [2];
  logic        drop_m [2];

  fsm_write_data u_delta (
    .clk(clk), .reset(reset), .update_req(update_req),
    .game_state(game_state), .ball_x(ball_x), .ball_y(ball_y),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .player_1_score(player_1_score), .player_2_score(player_2_score),
    .addr_a(addr_m[0]), .data_a(data_m[0]), .wren_a(wren_m[0]),
    .busy(busy_m[0]), .done(done_m[0]), .req_dropped(drop_m[0])
  );

  fsm_write_data #(.FORCE_ALL(1'b1)) u_force (
    .clk(clk), .reset(reset), .update_req(update_req),
    .game_state(game_state), .ball_x(ball_x), .ball_y(ball_y),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .player_1_score(player_1_score), .player_2_score(player_2_score),
    .addr_a(addr_m[1]), .data_a(data_m[1]), .wren_a(wren_m[1]),
    .busy(busy_m[1]), .done(done_m[1]), .req_dropped(drop_m[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          edge_n;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         wq [2][$];
  int          dq [2][$];
  logic [15:0] sh [7];
  bit          first_m;
  int          acc_e, next_acc, drop_edge;
  int          n_cmp = 0, n_fail = 0;
  bit          stim_done = 1'b0;

  function automatic logic [15:0] addr_of(input int i);
    case (i)
      0: return 16'h800F;
      1: return 16'h8008;
      2: return 16'h8009;
      3: return 16'h8002;
      4: return 16'h8004;
      5: return 16'h800D;
      default: return 16'h800E;
    endcase
  endfunction

  function automatic void check(input string name, input int d, input logic [31:0] got,
                                input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d: got 0x%0h, expected 0x%0h", name, d, cyc, got, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      wq[d].delete();
      dq[d].delete();
    end
    for (int i = 0; i < 7; i++) sh[i] = '0;
    first_m   = 1'b1;
    acc_e     = -100;
    next_acc  = 0;
    drop_edge = 1 << 30;
  endfunction

  // Request seen at edge e with the current input values
  function automatic void model_req(input int e);
    logic [15:0] v [7];
    wr_t w;
    v[0] = {14'd0, game_state};
    v[1] = {6'd0, ball_x};
    v[2] = {6'd0, ball_y};
    v[3] = {6'd0, paddle1_y};
    v[4] = {6'd0, paddle2_y};
    v[5] = {9'd0, player_1_score};
    v[6] = {9'd0, player_2_score};
    if (e >= next_acc) begin
      acc_e    = e;
      next_acc = e + 9;
      for (int i = 0; i < 7; i++) begin
        w.edge_n = e + 1 + i;
        w.addr   = addr_of(i);
        w.data   = v[i];
        if (first_m || v[i] != sh[i]) wq[0].push_back(w);
        wq[1].push_back(w);
        sh[i] = v[i];
      end
      dq[0].push_back(e + 8);
      dq[1].push_back(e + 8);
      first_m = 1'b0;
    end else if (e < drop_edge) begin
      drop_edge = e;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    update_req = 1'b1;
    model_req(cyc + 1);
    @(negedge clk);
    update_req = 1'b0;
  endtask

  task automatic set_all(input logic [1:0] gs, input logic [9:0] bx, input logic [9:0] by,
                         input logic [9:0] p1, input logic [9:0] p2,
                         input logic [6:0] s1, input logic [6:0] s2);
    game_state = gs; ball_x = bx; ball_y = by; paddle1_y = p1; paddle2_y = p2;
    player_1_score = s1; player_2_score = s2;
  endtask

  task automatic monitor();
    wr_t w;
    int  de;
    while (!stim_done) begin
      @(negedge clk or negedge reset);
      if (!reset) begin
        #1;
        for (int d = 0; d < 2; d++) begin
          check("rst_addr", d, 32'(addr_m[d]), 32'd0);
          check("rst_data", d, 32'(data_m[d]), 32'd0);
          check("rst_wren", d, 32'(wren_m[d]), 32'd0);
          check("rst_busy", d, 32'(busy_m[d]), 32'd0);
          check("rst_done", d, 32'(done_m[d]), 32'd0);
          check("rst_req_dropped", d, 32'(drop_m[d]), 32'd0);
        end
        continue;
      end
      for (int d = 0; d < 2; d++) begin
        while (wq[d].size() > 0 && wq[d][0].edge_n < cyc) begin
          w = wq[d].pop_front();
          check("write_missing", d, 32'(0), 32'(w.addr));
        end
        if (wren_m[d]) begin
          if (wq[d].size() == 0) begin
            check("write_unexpected", d, 32'(addr_m[d]), 32'd0);
          end else begin
            w = wq[d].pop_front();
            check("write_edge", d, 32'(cyc), 32'(w.edge_n));
            check("write_addr", d, 32'(addr_m[d]), 32'(w.addr));
            check("write_data", d, 32'(data_m[d]), 32'(w.data));
          end
        end
        while (dq[d].size() > 0 && dq[d][0] < cyc) begin
          de = dq[d].pop_front();
          check("done_missing", d, 32'(0), 32'(de));
        end
        if (done_m[d]) begin
          if (dq[d].size() == 0) begin
            check("done_unexpected", d, 32'(cyc), 32'd0);
          end else begin
            de = dq[d].pop_front();
            check("done_edge", d, 32'(cyc), 32'(de));
          end
        end
        check("busy", d, 32'(busy_m[d]), 32'(cyc >= acc_e && cyc < acc_e + 8));
        check("req_dropped", d, 32'(drop_m[d]), 32'(cyc >= drop_edge));
      end
    end
  endtask

  task automatic stimulus();
    model_reset();
    #1 reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(1);

    set_all(2'd1, 10'd320, 10'd240, 10'd200, 10'd210, 7'd3, 7'd5);
    pulse();
    idle(9);

    ball_x = 10'd321;
    pulse();
    idle(9);

    pulse();
    idle(2);
    pulse();
    idle(10);

    set_all(2'b11, 10'd321, 10'd240, 10'h3FF, 10'd210, 7'h7F, 7'd5);
    pulse();
    idle(9);

    repeat (25) begin
      if ($urandom_range(0, 1) == 1) begin
        set_all(2'($urandom), 10'($urandom), 10'($urandom), 10'($urandom),
                10'($urandom), 7'($urandom), 7'($urandom));
      end else begin
        case ($urandom_range(0, 6))
          0: game_state = 2'($urandom);
          1: ball_x = 10'($urandom);
          2: ball_y = 10'($urandom);
          3: paddle1_y = 10'($urandom);
          4: paddle2_y = 10'($urandom);
          5: player_1_score = 7'($urandom);
          default: player_2_score = 7'($urandom);
        endcase
      end
      pulse();
      ball_y = 10'($urandom);
      idle($urandom_range(0, 12));
    end
    idle(10);

    update_req = 1'b1;
    repeat (30) begin
      if ($urandom_range(0, 2) == 0) paddle2_y = 10'($urandom);
      model_req(cyc + 1);
      @(negedge clk);
    end
    update_req = 1'b0;
    idle(10);

    set_all(2'd2, 10'd100, 10'd50, 10'd60, 10'd70, 7'd9, 7'd11);
    pulse();
    idle(9);
    pulse();
    idle(3);
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_reset();
    idle(3);
    reset = 1'b1;
    idle(1);
    pulse();
    idle(12);

    for (int d = 0; d < 2; d++) begin
      check("writes_pending", d, 32'(wq[d].size()), 32'd0);
      check("done_pending", d, 32'(dq[d].size()), 32'd0);
    end
    stim_done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_write_data.md
# fsm_write_data

Write-side sequencer for the shared game-state memory. It snapshots the game-logic outputs (game state, ball position, paddle positions, scores) on an update request and writes them into the BRAM write port at the fixed game-state addresses, one word per cycle. It only writes fields whose value changed since their last write. It is the producer counterpart to the VGA-side read FSM, which polls the same addresses on port B.

## Interface
Parameters:
- game_state_address, 16'h800F: address of game state word
- ball_x_address, 16'h8008: address of ball X
- ball_y_address, 16'h8009: address of ball Y
- paddle1_y_address, 16'h8002: address of paddle 1 Y
- paddle2_y_address, 16'h8004: address of paddle 2 Y
- player_1_score_address, 16'h800D: address of player 1 score
- player_2_score_address, 16'h800E: address of player 2 score
- FORCE_ALL, 0: when 1, every pass writes all seven fields regardless of change

Ports:
- clk  in  1  system clock (50 MHz); all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- update_req  in  1  request a write pass; sampled each rising edge
- game_state  in  2  current game state
- ball_x, ball_y  in  10 each  ball position
- paddle1_y, paddle2_y  in  10 each  paddle positions
- player_1_score, player_2_score  in  7 each  scores
- addr_a  out  16  BRAM port A address
- data_a  out  16  BRAM port A write data, field zero-extended
- wren_a  out  1  BRAM port A write enable
- busy  out  1  high while a pass is in progress
- done  out  1  one-cycle pulse at end of pass
- req_dropped  out  1  sticky; set when update_req arrives while not IDLE

## Operation
- States: IDLE, WRITE (slot index 0..6), then back to IDLE.
- IDLE with update_req=1 at an edge:
  - capture all seven inputs into snapshot registers;
  - enter WRITE with idx=0 and set busy=1.
- Slot order (idx 0..6): game_state, ball_x, ball_y, paddle1_y, paddle2_y, player_1_score, player_2_score.
- In WRITE, each edge registers the outputs for slot idx, then idx increments:
  - dirty = (snapshot != shadow[idx]) OR first_pass OR FORCE_ALL;
  - dirty slot: addr_a = slot address, data_a = zero-extended snapshot, wren_a=1, shadow[idx] <= snapshot;
  - clean slot: wren_a=0; addr_a/data_a still driven with slot address/data; shadow unchanged.
- After slot 6, the next edge returns to IDLE with wren_a=0, addr_a=0, data_a=0, busy=0, done=1, first_pass cleared.
- The edge after that clears done.
- update_req sampled while state != IDLE: ignored (not queued) and req_dropped set; only reset clears req_dropped.
- Inputs may change during a pass; only the snapshot is written.

## Timing
- Reset values: addr_a=0, data_a=0, wren_a=0, busy=0, done=0, req_dropped=0, all shadows=0, first_pass=1, state IDLE.
- Reset asserted mid-pass: all outputs go to reset values immediately (asynchronous). No further slots are written. Next pass writes all seven fields.
- Request accepted at edge k: busy=1 after edge k. Slot i outputs are valid from edge k+1+i to edge k+2+i, so each write occupies exactly one cycle. done=1 and busy=0 from edge k+8 to k+9.
- Fixed latency of 8 cycles from accept to done, independent of how many slots are dirty.
- Edges k+1..k+8 ignore update_req. The earliest next accept is edge k+9.
- update_req held high continuously: one pass every 9 cycles, and req_dropped sets.
- The BRAM samples addr_a/data_a/wren_a on the rising edge after they are registered. The reader on port B samples on the falling edge, so there is no same-edge hazard on our side.

## Test plan
- **Full first pass:** reset, then pulse req with gs=1, bx=320, by=240, p1=200, p2=210, s1=3, s2=5.
  - Expect writes on 7 consecutive cycles: 0x800F=0x0001, 0x8008=0x0140, 0x8009=0x00F0, 0x8002=0x00C8, 0x8004=0x00D2, 0x800D=0x0003, 0x800E=0x0005.
  - Expect done exactly 8 edges after accept.
- **Delta pass:** repeat with only bx=321.
  - Expect wren_a=1 only in the slot 1 cycle (0x8008=0x0141).
  - Expect wren_a=0 in the other six slots; done still at +8.
- **Busy overlap:** pulse req at accept+3.
  - Expect it ignored, no extra pass, and req_dropped=1 held until reset.
- **Async reset in slot 3:** assert reset mid-cycle.
  - Expect wren_a/busy to drop with no clock edge.
  - Release reset, then request with unchanged values: expect all 7 writes.
- **FORCE_ALL=1:** two requests with identical values.
  - Expect 7 writes in each pass.
- **Width/extension:** s1=7'h7F, p1=10'h3FF, gs=2'b11.
  - Expect data 0x007F, 0x03FF, 0x0003 with upper bits zero.
